data_mem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. Serves word-aligned reads and writes on a single-port word array with a configurable read latency, and signals the core through a ready/valid response pair. Latches each request, counts out wait states, and returns read data with a one-cycle valid strobe. Flags misaligned, out-of-range and conflicting requests.

---
 rtl/arc_mem_pkg.sv | 14 +
 rtl/data_mem_array.sv | 29 ++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 tb/tb_data_mem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/arc_mem_pkg.sv
// Shared types and constants for the data-memory responder slice.
// The FSM state encoding and the word geometry live here.
package arc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_LSB   = $clog2(WORD_BYTES);

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// The read register only loads when re is high, so it holds its last value.
module data_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_reg [DEPTH_WORDS];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[idx] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[idx];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port: legality check, wait-state
// counter and registered ready/valid/error handshake around data_mem_array.
module data_mem_responder
    import arc_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr_Data,
    input  logic [31:0] i_data_Wr,
    input  logic        i_con_MemWrite,
    input  logic        i_con_MemRead,
    output logic [31:0] o_data_Rd,
    output logic        o_con_Ready,
    output logic        o_con_RdValid,
    output logic        o_con_Err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    mem_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             pend_ok_reg, pend_ok_next;
    logic             data_ok_reg, data_ok_next;
    logic             ready_reg, ready_next;
    logic             rdvalid_reg, rdvalid_next;
    logic             err_reg, err_next;

    logic [IDX_W-1:0] req_idx;
    logic             misaligned;
    logic             out_of_range;
    logic             illegal;
    logic             accept_rd;
    logic             accept_wr;
    logic             completing;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      ram_rdata;

    assign req_idx      = i_addr_Data[WORD_LSB +: IDX_W];
    assign misaligned   = |i_addr_Data[WORD_LSB-1:0];
    assign out_of_range = |i_addr_Data[31:WORD_LSB+IDX_W];
    assign illegal      = misaligned | out_of_range | (i_con_MemRead & i_con_MemWrite);

    assign accept_rd  = ready_reg & i_con_MemRead & ~i_con_MemWrite;
    assign accept_wr  = ready_reg & i_con_MemWrite & ~i_con_MemRead & ~illegal;
    assign completing = (state_reg == WAIT) && (cnt_reg == '0);

    // Writes are only accepted outside WAIT, so the port address can follow
    // the live request except while a read is being counted out.
    assign ram_idx = (state_reg == WAIT) ? idx_reg : req_idx;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        pend_ok_next = pend_ok_reg;
        data_ok_next = data_ok_reg;
        rdvalid_next = 1'b0;
        err_next     = ready_reg & (i_con_MemRead | i_con_MemWrite) & illegal;

        case (state_reg)
            IDLE, RESP: begin
                state_next = IDLE;
                if (accept_rd) begin
                    state_next   = WAIT;
                    cnt_next     = CNT_INIT;
                    idx_next     = req_idx;
                    pend_ok_next = ~illegal;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next   = RESP;
                    rdvalid_next = 1'b1;
                    data_ok_next = pend_ok_reg;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next != WAIT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            pend_ok_reg <= 1'b0;
            data_ok_reg <= 1'b0;
            ready_reg   <= 1'b1;
            rdvalid_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            pend_ok_reg <= pend_ok_next;
            data_ok_reg <= data_ok_next;
            ready_reg   <= ready_next;
            rdvalid_reg <= rdvalid_next;
            err_reg     <= err_next;
        end
    end

    data_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (i_clk),
        .we   (accept_wr),
        .re   (completing),
        .idx  (ram_idx),
        .wdata(i_data_Wr),
        .rdata(ram_rdata)
    );

    // Illegal reads and the post-reset state present zero instead of stale RAM output.
    assign o_data_Rd     = data_ok_reg ? ram_rdata : 32'h0;
    assign o_con_Ready   = ready_reg;
    assign o_con_RdValid = rdvalid_reg;
    assign o_con_Err     = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with three instances at read
// latencies 1, 2 and 8; instance 1 (latency 2) carries the main sequence.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic        mw_s    [3];
    logic        mr_s    [3];
    wire  [31:0] rdata_s [3];
    wire         ready_s [3];
    wire         rdv_s   [3];
    wire         err_s   [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            data_mem_responder #(
                .DEPTH_WORDS (1024),
                .READ_LATENCY(gi == 0 ? 1 : (gi == 1 ? 2 : 8))
            ) u_dut (
                .i_clk         (clk),
                .i_rst         (rst),
                .i_addr_Data   (addr_s[gi]),
                .i_data_Wr     (wdata_s[gi]),
                .i_con_MemWrite(mw_s[gi]),
                .i_con_MemRead (mr_s[gi]),
                .o_data_Rd     (rdata_s[gi]),
                .o_con_Ready   (ready_s[gi]),
                .o_con_RdValid (rdv_s[gi]),
                .o_con_Err     (err_s[gi])
            );
        end
    endgenerate

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 8);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d);
        addr_s[k]  = a;
        wdata_s[k] = d;
        mw_s[k]    = 1'b1;
        tick();
        mw_s[k] = 1'b0;
        $display("write  inst=%0d addr=%h data=%h err=%0d", k, a, d, err_s[k]);
    endtask

    // Issues one read from an idle/RESP instance and checks handshake timing and data.
    task automatic read_chk(input int k, input logic [31:0] a, input logic [31:0] exp,
                            input string tag);
        int n;
        addr_s[k] = a;
        mr_s[k]   = 1'b1;
        tick();
        mr_s[k] = 1'b0;
        chk({tag, "_ready_low"}, 32'(ready_s[k]), 32'd0);
        n = 0;
        while (rdv_s[k] !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (rdv_s[k] !== 1'b1) chk({tag, "_wait_ready"}, 32'(ready_s[k]), 32'd0);
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat_of(k)));
        chk({tag, "_data"}, rdata_s[k], exp);
        chk({tag, "_resp_ready"}, 32'(ready_s[k]), 32'd1);
        $display("read   inst=%0d addr=%h data=%h lat=%0d", k, a, rdata_s[k], n);
        tick();
        chk({tag, "_valid_drop"}, 32'(rdv_s[k]), 32'd0);
        chk({tag, "_data_hold"}, rdata_s[k], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int t1;
        int t2;
        logic seen;

        for (int k = 0; k < 3; k++) begin
            addr_s[k]  = 32'h0;
            wdata_s[k] = 32'h0;
            mw_s[k]    = 1'b0;
            mr_s[k]    = 1'b0;
        end

        // Reset held for three edges, then released
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready_%0d", k), 32'(ready_s[k]), 32'd1);
            chk($sformatf("rst_rdv_%0d", k), 32'(rdv_s[k]), 32'd0);
            chk($sformatf("rst_err_%0d", k), 32'(err_s[k]), 32'd0);
            chk($sformatf("rst_data_%0d", k), rdata_s[k], 32'h0);
        end

        // Write then read on the very next edge returns the new word
        do_write(1, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("wr_ready", 32'(ready_s[1]), 32'd1);
        chk("wr_err", 32'(err_s[1]), 32'd0);
        read_chk(1, 32'h0000_0010, 32'hDEAD_BEEF, "rd10");

        // Misaligned write is flagged and discarded
        do_write(1, 32'h0000_0013, 32'h1234_5678);
        chk("mis_err", 32'(err_s[1]), 32'd1);
        chk("mis_ready", 32'(ready_s[1]), 32'd1);
        tick();
        chk("mis_err_drop", 32'(err_s[1]), 32'd0);
        read_chk(1, 32'h0000_0010, 32'hDEAD_BEEF, "rd10_after_mis");

        // Out-of-range read: error strobe, then a completed read of zero
        addr_s[1] = 32'h0000_1000;
        mr_s[1]   = 1'b1;
        tick();
        mr_s[1] = 1'b0;
        chk("oor_err", 32'(err_s[1]), 32'd1);
        chk("oor_ready", 32'(ready_s[1]), 32'd0);
        tick();
        chk("oor_err_drop", 32'(err_s[1]), 32'd0);
        chk("oor_rdv_early", 32'(rdv_s[1]), 32'd0);
        tick();
        chk("oor_rdv", 32'(rdv_s[1]), 32'd1);
        chk("oor_data", rdata_s[1], 32'h0);
        tick();

        // Simultaneous read and write: error only, word untouched
        do_write(1, 32'h0000_0020, 32'hCAFE_F00D);
        addr_s[1]  = 32'h0000_0020;
        wdata_s[1] = 32'hFFFF_FFFF;
        mr_s[1]    = 1'b1;
        mw_s[1]    = 1'b1;
        tick();
        mr_s[1] = 1'b0;
        mw_s[1] = 1'b0;
        chk("both_err", 32'(err_s[1]), 32'd1);
        chk("both_ready", 32'(ready_s[1]), 32'd1);
        tick();
        chk("both_err_drop", 32'(err_s[1]), 32'd0);
        chk("both_rdv", 32'(rdv_s[1]), 32'd0);
        read_chk(1, 32'h0000_0020, 32'hCAFE_F00D, "rd20");

        // Back-to-back reads with the request held, per latency.
        // The second read is accepted on the edge closing the RESP cycle,
        // so strobes are LAT+1 edges apart.
        for (int k = 0; k < 3; k++) begin
            do_write(k, 32'h0000_0010, 32'h1111_0000);
            do_write(k, 32'h0000_0014, 32'h2222_0000);
            addr_s[k] = 32'h0000_0010;
            mr_s[k]   = 1'b1;
            tick();
            n = 0;
            while (rdv_s[k] !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            t1 = cyc;
            chk($sformatf("b2b_lat1_%0d", k), 32'(n), 32'(lat_of(k)));
            chk($sformatf("b2b_data1_%0d", k), rdata_s[k], 32'h1111_0000);
            $display("read   inst=%0d addr=00000010 data=%h lat=%0d", k, rdata_s[k], n);
            addr_s[k] = 32'h0000_0014;
            tick();
            chk($sformatf("b2b_accept_%0d", k), 32'(ready_s[k]), 32'd0);
            n = 0;
            while (rdv_s[k] !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            mr_s[k] = 1'b0;
            t2 = cyc;
            chk($sformatf("b2b_lat2_%0d", k), 32'(n), 32'(lat_of(k)));
            chk($sformatf("b2b_data2_%0d", k), rdata_s[k], 32'h2222_0000);
            chk($sformatf("b2b_spacing_%0d", k), 32'(t2 - t1), 32'(lat_of(k) + 1));
            $display("read   inst=%0d addr=00000014 data=%h lat=%0d", k, rdata_s[k], n);
            tick();
            chk($sformatf("b2b_idle_%0d", k), 32'(ready_s[k]), 32'd1);
        end

        // Reset in the middle of a read aborts it
        addr_s[1] = 32'h0000_0010;
        mr_s[1]   = 1'b1;
        tick();
        mr_s[1] = 1'b0;
        tick();
        chk("abort_in_wait", 32'(ready_s[1]), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_ready_async", 32'(ready_s[1]), 32'd1);
        chk("abort_rdv_async", 32'(rdv_s[1]), 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (rdv_s[1] === 1'b1) seen = 1'b1;
        end
        chk("abort_no_rdv", 32'(seen), 32'd0);
        chk("abort_ready_after", 32'(ready_s[1]), 32'd1);
        $display("reset  inst=1 aborted pending read");
        read_chk(1, 32'h0000_0010, 32'h1111_0000, "rd10_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
